// File: rtl/led_row_scan_mux.sv
// led_row_scan_mux: N-row x M-column LED matrix scanner with a double-buffered
// frame. One row is lit at a time for DWELL cycles; rows advance in order and
// wrap at ROWS-1, which is the only point a newly loaded frame becomes visible.
// Optional build macro LED_SCAN_BLANK_EN inserts a dark BLANK interval of
// BLANK_CYCLES before every row to suppress ghosting.
//
// state | meaning
// IDLE  | scan stopped, matrix dark
// BLANK | dark gap before the current row (LED_SCAN_BLANK_EN only)
// SHOW  | current row lit with its column pattern
module led_row_scan_mux #(
    parameter int ROWS         = 7,
    parameter int COLS         = 5,
    parameter int DWELL        = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   load_valid,
    input  logic [ROWS*COLS-1:0]   load_data,
    output logic [ROWS-1:0]        row_en,
    output logic [COLS-1:0]        col_data,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int RW      = $clog2(ROWS);
    localparam int CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef LED_SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd2} state_t;
`endif

    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ROWS*COLS-1:0]   active_q, active_d;
    logic [ROWS*COLS-1:0]   pending_q, pending_d;
    logic                   pending_valid_q, pending_valid_d;
    logic [ROWS-1:0]        row_en_q, row_en_d;
    logic [COLS-1:0]        col_data_q, col_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;
    logic                   swap;

    // Next-state, buffer management and registered-output precompute.
    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        cnt_d           = cnt_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        frame_done_d    = 1'b0;
        swap            = 1'b0;

        if (load_valid) begin
            pending_d       = load_data;
            pending_valid_d = 1'b1;
        end

        if (!enable) begin
            state_d = IDLE;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    swap  = 1'b1;
                    row_d = '0;
`ifdef LED_SCAN_BLANK_EN
                    state_d = BLANK;
                    cnt_d   = CW'(BLANK_CYCLES - 1);
`else
                    state_d = SHOW;
                    cnt_d   = CW'(DWELL - 1);
`endif
                end
`ifdef LED_SCAN_BLANK_EN
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = SHOW;
                        cnt_d   = CW'(DWELL - 1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
`endif
                SHOW: begin
                    if (cnt_q == '0) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            swap         = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
`ifdef LED_SCAN_BLANK_EN
                        state_d = BLANK;
                        cnt_d   = CW'(BLANK_CYCLES - 1);
`else
                        cnt_d = CW'(DWELL - 1);
`endif
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // A load coinciding with the frame boundary bypasses pending so the
        // newest frame is the one shown.
        if (swap) begin
            if (load_valid) begin
                active_d        = load_data;
                pending_valid_d = 1'b0;
            end else if (pending_valid_q) begin
                active_d        = pending_q;
                pending_valid_d = 1'b0;
            end
        end

        row_en_d   = '0;
        col_data_d = '0;
        if (state_d == SHOW) begin
            row_en_d[row_d] = 1'b1;
            col_data_d      = active_d[row_d*COLS +: COLS];
        end
        busy_d = (state_d != IDLE);
    end

    // State, buffers and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            row_q           <= '0;
            cnt_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            row_en_q        <= '0;
            col_data_q      <= '0;
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            cnt_q           <= cnt_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            row_en_q        <= row_en_d;
            col_data_q      <= col_data_d;
            frame_done_q    <= frame_done_d;
            busy_q          <= busy_d;
        end
    end

    assign row_en     = row_en_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
